// File: rtl/cvw_pkg.sv
// Shared configuration and encodings for the radix-4 divide/sqrt datapath.
// Holds the cvw_t configuration struct, the one-hot signed-digit constants
// and the digit-generator state enum.
package cvw_pkg;

  typedef struct packed {
    int unsigned DIVb;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT_CFG = '{DIVb: 32'd4};

  // One-hot signed radix-4 digit: [3]=+2 [2]=+1 [1]=-1 [0]=-2, all clear = 0
  localparam logic [3:0] UDIG_P2   = 4'b1000;
  localparam logic [3:0] UDIG_P1   = 4'b0100;
  localparam logic [3:0] UDIG_ZERO = 4'b0000;
  localparam logic [3:0] UDIG_M1   = 4'b0010;
  localparam logic [3:0] UDIG_M2   = 4'b0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } digitgen_state_e;

endpackage

// File: rtl/fdivsqrt_r4_recode.sv
// Booth-style radix-4 recode of one overlapping bit triplet into a one-hot
// signed digit.
//   bits_i    : {b[2j+1], b[2j], b[2j-1]}
//   udig_c_o  : one-hot digit, value -2*bits_i[2] + bits_i[1] + bits_i[0]
module fdivsqrt_r4_recode
  import cvw_pkg::*;
(
  input  logic [2:0] bits_i,
  output logic [3:0] udig_c_o
);

  always_comb begin : p_recode
    udig_c_o = UDIG_ZERO;
    case (bits_i)
      3'b001, 3'b010: udig_c_o = UDIG_P1;
      3'b011:         udig_c_o = UDIG_P2;
      3'b100:         udig_c_o = UDIG_M2;
      3'b101, 3'b110: udig_c_o = UDIG_M1;
      default:        udig_c_o = UDIG_ZERO;
    endcase
  end

endmodule

// File: rtl/fdivsqrt_r4_digitgen.sv
// Serial radix-4 signed-digit generator. Accepts an unsigned U1.DIVb operand
// and emits DIVb/2+1 digits MSB-first on a valid/ready stream, each with the
// matching Q1.DIVb position mask C.
//   clk, reset          : clock, asynchronous active-low reset
//   InValid/InReady/V   : operand input handshake and value
//   OutValid/OutReady   : digit output handshake
//   udigit, C, OutLast  : one-hot digit, position mask, final-digit flag
// Build option: FDIVSQRT_DIGITGEN_EARLYTERM_EN ends an operand as soon as
// every remaining digit is zero.
module fdivsqrt_r4_digitgen
  import cvw_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT_CFG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [P.DIVb:0]   V,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [3:0]        udigit,
  output logic [P.DIVb+1:0] C,
  output logic              OutLast
);

  localparam int unsigned DIVB = P.DIVb;
  localparam int unsigned NDIG = DIVB / 2 + 1;
  localparam int unsigned SHW  = DIVB + 3;
  localparam int unsigned CW   = DIVB + 2;
  localparam int unsigned CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIVB % 2) != 0) begin : g_divb_odd
    $error("fdivsqrt_r4_digitgen: P.DIVb must be even");
  end

  digitgen_state_e  state_q, state_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]    c_q, c_d;
  logic [3:0]       udig_q, udig_d;
  logic             last_q, last_d;
  logic             in_ready_c;
  logic             load_c;
  logic [3:0]       rec_udig_c;

  // Shift register carries {b[DIVb+1]=0, V, b[-1]=0}; top three bits form the current triplet
  always_comb begin : p_next
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    c_d     = c_q;

    // Accept in IDLE, or on the final-digit handshake to avoid a bubble
    in_ready_c = (state_q == IDLE) || (last_q && OutReady);
    load_c     = InValid && in_ready_c;

    if (load_c) begin
      state_d = RUN;
      sh_d    = {1'b0, V, 1'b0};
      cnt_d   = '0;
      c_d     = {2'b11, {(CW-2){1'b0}}};
    end else if ((state_q == RUN) && OutReady) begin
      if (last_q) begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
        c_d     = '0;
      end else begin
        sh_d  = {sh_q[SHW-3:0], 2'b00};
        cnt_d = cnt_q + CNTW'(1);
        c_d   = $unsigned($signed(c_q) >>> 2);
      end
    end
  end

  fdivsqrt_r4_recode u_recode (
    .bits_i   (sh_d[SHW-1 -: 3]),
    .udig_c_o (rec_udig_c)
  );

  // Digit and last flag are registered from the next shift/counter state
  always_comb begin : p_digit_next
    udig_d = UDIG_ZERO;
    last_d = 1'b0;
    if (state_d == RUN) begin
      udig_d = rec_udig_c;
`ifdef FDIVSQRT_DIGITGEN_EARLYTERM_EN
      last_d = (cnt_d == CNTW'(NDIG - 1)) || !(|sh_d[DIVB:0]);
`else
      last_d = (cnt_d == CNTW'(NDIG - 1));
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin : p_regs
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      udig_q  <= UDIG_ZERO;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      udig_q  <= udig_d;
      last_q  <= last_d;
    end
  end

  assign InReady  = in_ready_c;
  assign OutValid = (state_q == RUN);
  assign udigit   = udig_q;
  assign C        = c_q;
  assign OutLast  = last_q;

endmodule

// File: tb/tb_fdivsqrt_r4_digitgen.sv
// Scoreboard bench for fdivsqrt_r4_digitgen at DIVb=4 (three digits per operand).
module tb_fdivsqrt_r4_digitgen;
  import cvw_pkg::*;

  localparam int DIVB = 4;
  localparam int NDIG = DIVB / 2 + 1;
  localparam cvw_t CFG = '{DIVb: 32'd4};
`ifdef FDIVSQRT_DIGITGEN_EARLYTERM_EN
  localparam int EXP_NDIG_10000 = 1;
`else
  localparam int EXP_NDIG_10000 = 3;
`endif

  typedef struct {
    logic [3:0] ud;
    logic [5:0] c;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       InValid;
  logic       InReady;
  logic [4:0] V;
  logic       OutValid;
  logic       OutReady;
  logic [3:0] udigit;
  logic [5:0] C;
  logic       OutLast;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   v_q[$];
  int   recon = 0;
  int   dig_k = 0;
  int   cur_run = 0;
  int   last_run = 0;
  int   last_ndig = 0;
  bit   acc_pend = 0;

  fdivsqrt_r4_digitgen #(.P(CFG)) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .V        (V),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .udigit   (udigit),
    .C        (C),
    .OutLast  (OutLast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic int digval(input logic [3:0] u);
    case (u)
      4'b1000: return 2;
      4'b0100: return 1;
      4'b0010: return -1;
      4'b0001: return -2;
      default: return 0;
    endcase
  endfunction

  // Reference digits straight from the bit-weight formula
  function automatic void push_expected(input logic [4:0] v);
    logic [6:0] ext;
    exp_t e;
    int   base;
    int   d;
    ext = {1'b0, v, 1'b0};  // ext[i+1] = b[i]
    for (int k = 0; k < NDIG; k++) begin
      base = DIVB - 2 * k;
      d = (ext[base+2] ? -2 : 0) + (ext[base+1] ? 1 : 0) + (ext[base] ? 1 : 0);
      case (d)
        2:       e.ud = 4'b1000;
        1:       e.ud = 4'b0100;
        -1:      e.ud = 4'b0010;
        -2:      e.ud = 4'b0001;
        default: e.ud = 4'b0000;
      endcase
      for (int i = 0; i < 6; i++) e.c[i] = (i >= base);
      e.last = (k == NDIG - 1);
`ifdef FDIVSQRT_DIGITGEN_EARLYTERM_EN
      if ((int'(v) & ((1 << base) - 1)) == 0) e.last = 1'b1;
`endif
      exp_q.push_back(e);
      if (e.last) break;
    end
    v_q.push_back(int'(v));
  endfunction

  // Output monitor: scoreboard compare, value reconstruction, latency and run length
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      v_q.delete();
      recon    = 0;
      dig_k    = 0;
      cur_run  = 0;
      acc_pend = 0;
    end else begin
      if (acc_pend) chk("first_latency", 32'(OutValid), 32'd1);
      if (OutValid) begin
        cur_run++;
        if (exp_q.size() == 0) begin
          chk("sb_underrun", 32'(OutValid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("udigit", 32'(udigit), 32'(e.ud));
          chk("C", 32'(C), 32'(e.c));
          chk("OutLast", 32'(OutLast), 32'(e.last));
          if (OutReady) begin
            e = exp_q.pop_front();
            recon += digval(udigit) * (1 << (DIVB - 2 * dig_k));
            dig_k++;
            if (e.last) begin
              if (v_q.size() != 0) chk("recon", 32'(recon), 32'(v_q.pop_front()));
              last_ndig = dig_k;
              recon = 0;
              dig_k = 0;
            end
          end
        end
      end else begin
        if (cur_run != 0) last_run = cur_run;
        cur_run = 0;
        chk("idle_udigit", 32'(udigit), 32'd0);
      end
      acc_pend = InValid && InReady;
      if (acc_pend) push_expected(V);
    end
  end

  // Offer v until accepted; InValid is left high for the caller to manage
  task automatic send(input logic [4:0] v);
    bit got = 0;
    InValid = 1'b1;
    V = v;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = InReady;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !OutValid;
    end
    chk("drain_timeout", 32'(OutValid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Continuous operand stream, optionally with random output back-pressure
  task automatic run_stream(input int n, input bit rnd_ready, input bit seq);
    bit acc;
    int idx = 1;
    InValid = 1'b1;
    V = seq ? 5'd0 : 5'($urandom);
    for (int cyc = 0; cyc < 3000 && InValid; cyc++) begin
      if (rnd_ready) OutReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = InValid && InReady;
      @(posedge clk);
      #1;
      if (acc) begin
        if (idx < n) begin
          V = seq ? 5'(idx) : 5'($urandom);
          idx++;
        end else begin
          InValid = 1'b0;
        end
      end
    end
    OutReady = 1'b1;
    chk("stream_done", 32'(InValid), 32'd0);
    wait_idle();
  endtask

  initial begin
    InValid  = 1'b0;
    OutReady = 1'b1;
    V        = '0;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_InReady", 32'(InReady), 32'd1);
    chk("rst_OutValid", 32'(OutValid), 32'd0);
    chk("rst_OutLast", 32'(OutLast), 32'd0);
    chk("rst_udigit", 32'(udigit), 32'd0);
    chk("rst_C", 32'(C), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed operands
    send(5'b10110); InValid = 1'b0; wait_idle();
    send(5'b11111); InValid = 1'b0; wait_idle();
    send(5'b10000); InValid = 1'b0; wait_idle();
    chk("ndig_10000", 32'(last_ndig), 32'(EXP_NDIG_10000));

    // Back-pressure held on digit 1
    send(5'b10110); InValid = 1'b0;
    @(posedge clk); #1;
    OutReady = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_udigit", 32'(udigit), 32'b1000);
    chk("stall_C", 32'(C), 32'b111100);
    OutReady = 1'b1;
    wait_idle();

    // Back-to-back operands with no bubble
    send(5'b10110);
    send(5'b11111);
    InValid = 1'b0;
    wait_idle();
    chk("b2b_run", 32'(last_run), 32'd6);

    // Reset during digit 1 discards the operand
    send(5'b10110); InValid = 1'b0;
    @(posedge clk); #1;
    chk("mid_valid", 32'(OutValid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_OutValid", 32'(OutValid), 32'd0);
    chk("mid_rst_InReady", 32'(InReady), 32'd1);
    chk("mid_rst_C", 32'(C), 32'd0);
    chk("mid_rst_udigit", 32'(udigit), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_OutValid_next", 32'(OutValid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    send(5'b11111); InValid = 1'b0; wait_idle();

    // Every operand value, then random values under random back-pressure
    run_stream(32, 1'b0, 1'b1);
    run_stream(40, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fdivsqrt_r4_digitgen.md
FDIVSQRT_R4_DIGITGEN -- requirements
Module: fdivsqrt_r4_digitgen

Interface
REQ-001 SHALL have parameter: P, none (required), cvw_t configuration; width set by P.DIVb, which SHALL be even (elaboration error otherwise).
REQ-002 SHALL have localparam: NDIG, P.DIVb/2+1, digits per operand.
REQ-003 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: InValid  input  1  operand V offered.
REQ-006 SHALL have port: InReady  output  1  operand accepted when InValid&InReady.
REQ-007 SHALL have port: V  input  P.DIVb+1  unsigned U1.DIVb value to recode.
REQ-008 SHALL have port: OutValid  output  1  digit presented.
REQ-009 SHALL have port: OutReady  input  1  digit consumed when OutValid&OutReady.
REQ-010 SHALL have port: udigit  output  4  one-hot signed radix-4 digit: [3]=+2, [2]=+1, [1]=-1, [0]=-2, 0000=0.
REQ-011 SHALL have port: C  output  P.DIVb+2  position mask matching udigit, Q1.DIVb.
REQ-012 SHALL have port: OutLast  output  1  current digit is final digit of operand.

Function
REQ-013 SHALL recode V MSB-first into NDIG digits d_k in {-2..2} with V = sum d_k*4^-k, and digit k weighted at bit P.DIVb-2k.
REQ-014 SHALL compute d_k = -2*b[P.DIVb-2k+1] + b[P.DIVb-2k] + b[P.DIVb-2k-1], with b[P.DIVb+1]=0 and b[-1]=0.
REQ-015 SHALL present C for digit k with bits [P.DIVb+1 : P.DIVb-2k] set and all others clear.
REQ-016 SHALL implement states IDLE and RUN; reset enters IDLE.
REQ-017 IDLE: InReady=1, OutValid=0; on InValid, SHALL latch V into a shift register, clear digit counter, and go to RUN.
REQ-018 RUN: OutValid=1 with digit k from the top 3 shift bits; on OutReady SHALL shift left 2, increment k, and advance C by arithmetic shift right 2.
REQ-019 With OutReady low, udigit, C and OutLast SHALL hold stable.
REQ-020 OutLast SHALL be 1 when k=NDIG-1.
REQ-021 Handshake on the last digit SHALL return to IDLE.
REQ-022 InReady SHALL also be 1 in RUN when OutLast&OutReady, so a new operand loads in the same cycle and digit 0 appears next cycle with no bubble.
REQ-023 First digit SHALL appear the cycle after acceptance.
REQ-024 Without stalls, an operand SHALL occupy exactly NDIG consecutive OutValid cycles.
REQ-025 InValid in RUN other than the REQ-022 case SHALL be ignored (InReady=0); V SHALL be sampled only on accept.
REQ-026 udigit SHALL be 0000 whenever OutValid=0.

Reset
REQ-027 Reset assertion SHALL, at any time including mid-operand, force IDLE and discard the operand.
REQ-028 Reset assertion SHALL set InReady=1, OutValid=0, OutLast=0, udigit=0000, C=0, and counter and shift register to 0.
REQ-029 After deassertion, the first accept SHALL behave as from power-up.

Configuration
REQ-030 With FDIVSQRT_DIGITGEN_EARLYTERM_EN defined, OutLast SHALL additionally assert on digit k when all shift-register bits below the current pair are zero (all remaining digits zero), and the operand SHALL end there.
REQ-031 Without FDIVSQRT_DIGITGEN_EARLYTERM_EN, exactly NDIG digits SHALL always be emitted and no zero-detect logic SHALL exist.

Structure
REQ-032 Digit encoding constants (UDIG_P2, UDIG_P1, UDIG_ZERO, UDIG_M1, UDIG_M2) and the IDLE/RUN state enum SHALL reside in the cvw package.
REQ-033 Combinational 3-bit to one-hot recode SHALL be sub-module fdivsqrt_r4_recode.
REQ-034 FSM, counter, shift register and C register SHALL reside in the top module.

Verification (DIVb=4, NDIG=3 bench config)
REQ-035 V=1_0110, OutReady=1 -> udigit 0100,1000,0001; C 110000,111100,111111; OutLast on third digit only.
REQ-036 V=1_1111 -> udigit 1000,0000,0010; digits sum to 1.9375.
REQ-037 V=1_0000 -> macro off: 0100,0000,0000 with 3 digits; macro on: single digit 0100 with OutLast=1.
REQ-038 OutReady held low 5 cycles on digit 1 of V=1_0110 -> udigit=1000 and C=111100 held stable; sequence completes unchanged on release.
REQ-039 Back-to-back operands 1_0110 then 1_1111 with InValid high -> second accepted in the last-digit handshake cycle; 6 consecutive OutValid cycles.
REQ-040 Reset asserted during digit 1 -> next cycle OutValid=0, InReady=1, C=0; new operand yields correct digits.
REQ-041 All digit streams fed to the team's radix-4 on-the-fly converter SHALL reconstruct V exactly.
